// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: serves one word read/write at a time
// from on-chip storage after LATENCY wait cycles, with valid/ready on both channels.
module dmem_responder #(
    parameter int ADDR_W  = 7,
    parameter int NWORDS  = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0]  LAT_CNT  = 4'(LATENCY);
    localparam logic [31:0] NWORDS_U = 32'(NWORDS);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic [31:0]       mem_q [NWORDS];

    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_in_range;
    logic              mem_we;

    // Access operands: live request inputs when committing on the accept edge
    // (LATENCY=0), otherwise the values latched at accept.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = req_wr;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_in_range = (32'(acc_addr) < NWORDS_U);
    end

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = LAT_CNT;
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The access itself happens on the edge that enters RESP.
        if (state_q != S_RESP && state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !acc_in_range;
            rsp_rdata_d = (!acc_wr && acc_in_range) ? mem_q[acc_addr] : '0;
            mem_we      = acc_wr && acc_in_range && rst_n;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Storage: byte-masked write, never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses NWORDS=100/LATENCY=2, instance 1
// uses NWORDS=128/LATENCY=0. Table of transactions plus reset corner sequences.
module tb_dmem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [6:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb [$];

    typedef struct {
        int          d;
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          hold;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(7), .NWORDS(100), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.ADDR_W(7), .NWORDS(128), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction: accept, bounded wait for response, optional
    // backpressure, handshake, and check the responder is idle again.
    task automatic do_txn(input int d, input bit wr, input logic [6:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input bit exp_err, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = (d == 0) ? LAT_A + 1 : LAT_B + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs; they must be ignored while busy.
        req_valid[d] = 1'b0;
        req_wr[d]    = ~wr;
        req_addr[d]  = addr ^ 7'h01;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'hF;
        chk("busy_after_accept", {30'd0, req_ready[d], busy[d]}, 32'b01);
        n = 1;
        while (!rsp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
            return;
        end
        got = sb.pop_front();
        chk("rsp_latency", 32'(n), 32'(got.lat));
        chk("rsp_rdata", rsp_rdata[d], got.rdata);
        chk("rsp_err", 32'(rsp_err[d]), 32'(got.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_ctrl", {29'd0, rsp_valid[d], req_ready[d], busy[d]}, 32'b101);
            chk("bp_rdata", rsp_rdata[d], got.rdata);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("turnaround", {29'd0, rsp_valid[d], req_ready[d], busy[d]}, 32'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_wr[d]    = 1'b1;
            req_addr[d]  = 7'd1;
            req_wdata[d] = 32'hFFFF_FFFF;
            req_be[d]    = 4'hF;
            rsp_ready[d] = 1'b0;
        end
        rst_n = 1'b0;

        // Reset held with a pending request: nothing accepted.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk("reset_idle", {29'd0, req_ready[d], rsp_valid[d], busy[d]}, 32'b100);
        end
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("post_reset_idle", {29'd0, req_ready[d], rsp_valid[d], busy[d]}, 32'b100);

        //              d wr addr     wdata          be     exp_rdata      err hold
        vecs.push_back('{0, 1, 7'd5,   32'hDEADBEEF, 4'hF, 32'h0,         0, 0});
        vecs.push_back('{0, 0, 7'd5,   32'h0,        4'h0, 32'hDEADBEEF,  0, 0});
        vecs.push_back('{0, 1, 7'd9,   32'h11223344, 4'hF, 32'h0,         0, 0});
        vecs.push_back('{0, 1, 7'd9,   32'hAABBCCDD, 4'h5, 32'h0,         0, 0});
        vecs.push_back('{0, 0, 7'd9,   32'h0,        4'h0, 32'h11BB33DD,  0, 5});
        vecs.push_back('{0, 1, 7'd0,   32'hCAFEF00D, 4'hF, 32'h0,         0, 0});
        vecs.push_back('{0, 1, 7'd100, 32'h12345678, 4'hF, 32'h0,         1, 0});
        vecs.push_back('{0, 0, 7'd100, 32'h0,        4'h0, 32'h0,         1, 2});
        vecs.push_back('{0, 0, 7'd0,   32'h0,        4'h0, 32'hCAFEF00D,  0, 0});
        vecs.push_back('{0, 1, 7'd5,   32'hFFFFFFFF, 4'h0, 32'h0,         0, 0});
        vecs.push_back('{0, 0, 7'd5,   32'h0,        4'h0, 32'hDEADBEEF,  0, 0});
        vecs.push_back('{0, 1, 7'd99,  32'hA5A5A5A5, 4'hF, 32'h0,         0, 0});
        vecs.push_back('{0, 1, 7'd99,  32'h77000000, 4'h8, 32'h0,         0, 0});
        vecs.push_back('{0, 0, 7'd99,  32'h0,        4'h0, 32'h77A5A5A5,  0, 0});
        vecs.push_back('{0, 0, 7'd127, 32'h0,        4'h0, 32'h0,         1, 0});
        vecs.push_back('{1, 1, 7'd127, 32'h13579BDF, 4'hF, 32'h0,         0, 0});
        vecs.push_back('{1, 0, 7'd127, 32'h0,        4'h0, 32'h13579BDF,  0, 3});
        vecs.push_back('{1, 1, 7'd8,   32'h0BADF00D, 4'h3, 32'h0,         0, 0});
        vecs.push_back('{1, 1, 7'd8,   32'h12340000, 4'hC, 32'h0,         0, 0});
        vecs.push_back('{1, 0, 7'd8,   32'h0,        4'h0, 32'h1234F00D,  0, 0});

        foreach (vecs[i])
            do_txn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold);

        // Reset during WAIT drops an uncommitted write (LATENCY=2).
        do_txn(0, 1, 7'd3, 32'h1111_0000, 4'hF, 32'h0, 0, 0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 7'd3;
        req_wdata[0] = 32'h5; req_be[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("midwrite_wait", {30'd0, rsp_valid[0], busy[0]}, 32'b01);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midwrite_reset", {29'd0, req_ready[0], rsp_valid[0], busy[0]}, 32'b100);
        repeat (4) begin
            @(negedge clk);
            chk("midwrite_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        do_txn(0, 0, 7'd3, 32'h0, 4'h0, 32'h1111_0000, 0, 0);

        // LATENCY=0: response one cycle after accept; the write commits on the
        // accept edge, so a reset in RESP cannot undo it.
        do_txn(1, 1, 7'd3, 32'h2222_0000, 4'hF, 32'h0, 0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 7'd3;
        req_wdata[1] = 32'h5; req_be[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("lat0_rsp_next", {30'd0, rsp_valid[1], busy[1]}, 32'b11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("lat0_reset", {29'd0, req_ready[1], rsp_valid[1], busy[1]}, 32'b100);
        do_txn(1, 0, 7'd3, 32'h0, 4'h0, 32'h0000_0005, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
